// File: rtl/vc_fifo_bank.sv
// Bank of NUM_VC circular FIFOs, one per virtual channel, sharing a single write
// port and a single registered read port, with per-VC fill levels, flags and sticky errors.
module vc_fifo_bank #(
  parameter  int BW     = 6,
  parameter  int DEPTH  = 8,
  parameter  int NUM_VC = 2,
  localparam int VCW    = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
  localparam int FW     = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [VCW-1:0]       wr_vc,
  input  logic [BW-1:0]        wr_data,
  input  logic                 rd_en,
  input  logic [VCW-1:0]       rd_vc,
  output logic [BW-1:0]        rd_data,
  output logic                 rd_valid,
  input  logic [FW-1:0]        af_thr,
  input  logic [FW-1:0]        ae_thr,
  input  logic                 err_clr,
  output logic [NUM_VC*FW-1:0] fill,
  output logic [NUM_VC-1:0]    full,
  output logic [NUM_VC-1:0]    empty,
  output logic [NUM_VC-1:0]    almost_full,
  output logic [NUM_VC-1:0]    almost_empty,
  output logic [NUM_VC-1:0]    err_overflow,
  output logic [NUM_VC-1:0]    err_underflow,
  output logic                 err_any
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BW-1:0] mem [NUM_VC][DEPTH];
  logic [PW-1:0] wr_ptr [NUM_VC];
  logic [PW-1:0] rd_ptr [NUM_VC];
  logic [FW-1:0] fill_q [NUM_VC];

  logic              wr_vc_ok;
  logic              rd_vc_ok;
  logic [NUM_VC-1:0] wr_acc;
  logic [NUM_VC-1:0] rd_acc;
  logic [NUM_VC-1:0] wr_rej;
  logic [NUM_VC-1:0] rd_rej;
  logic [BW-1:0]     rd_word;

  // A select can only be out of range when NUM_VC is not a power of two
  if (NUM_VC == (1 << VCW)) begin : g_vc_full_range
    assign wr_vc_ok = 1'b1;
    assign rd_vc_ok = 1'b1;
  end else begin : g_vc_partial_range
    assign wr_vc_ok = (wr_vc < VCW'(NUM_VC));
    assign rd_vc_ok = (rd_vc < VCW'(NUM_VC));
  end

  // A full VC still accepts a write when the same cycle frees a slot on it
  always_comb begin
    wr_acc  = '0;
    rd_acc  = '0;
    wr_rej  = '0;
    rd_rej  = '0;
    rd_word = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (rd_en && rd_vc_ok && (rd_vc == VCW'(i))) begin
        rd_acc[i] = (fill_q[i] != '0);
        rd_rej[i] = (fill_q[i] == '0);
      end
      if (wr_en && wr_vc_ok && (wr_vc == VCW'(i))) begin
        wr_acc[i] = (fill_q[i] != FW'(DEPTH)) || rd_acc[i];
        wr_rej[i] = !wr_acc[i];
      end
      if (rd_acc[i]) begin
        rd_word = mem[i][rd_ptr[i]];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_VC; i++) begin
      if (wr_acc[i]) begin
        mem[i][wr_ptr[i]] <= wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_VC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        fill_q[i] <= '0;
      end
      err_overflow  <= '0;
      err_underflow <= '0;
      rd_data       <= '0;
      rd_valid      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_VC; i++) begin
        if (wr_acc[i]) begin
          wr_ptr[i] <= (wr_ptr[i] == PW'(DEPTH - 1)) ? '0 : wr_ptr[i] + PW'(1);
        end
        if (rd_acc[i]) begin
          rd_ptr[i] <= (rd_ptr[i] == PW'(DEPTH - 1)) ? '0 : rd_ptr[i] + PW'(1);
        end
        if (wr_acc[i] && !rd_acc[i]) begin
          fill_q[i] <= fill_q[i] + FW'(1);
        end else if (rd_acc[i] && !wr_acc[i]) begin
          fill_q[i] <= fill_q[i] - FW'(1);
        end
      end
      if (err_clr) begin
        err_overflow  <= '0;
        err_underflow <= '0;
      end else begin
        err_overflow  <= err_overflow | wr_rej;
        err_underflow <= err_underflow | rd_rej;
      end
      rd_valid <= |rd_acc;
      if (|rd_acc) begin
        rd_data <= rd_word;
      end
    end
  end

  for (genvar g = 0; g < NUM_VC; g++) begin : g_flags
    assign fill[g*FW +: FW] = fill_q[g];
    assign full[g]          = (fill_q[g] == FW'(DEPTH));
    assign empty[g]         = (fill_q[g] == '0);
    assign almost_full[g]   = (fill_q[g] >= af_thr);
    assign almost_empty[g]  = (fill_q[g] <= ae_thr);
  end

  assign err_any = |{err_overflow, err_underflow};

endmodule
